// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter:
// oversampling constants, FSM state encodings and a 3-input majority helper.
package uart_pkg;

  localparam int OVS       = 16;  // oversample ticks per bit
  localparam int SAMPLE_A  = 7;   // first vote sample within a bit
  localparam int SAMPLE_B  = 8;   // second vote sample
  localparam int SAMPLE_C  = 9;   // third vote sample, decision point
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..DIV-1 counter, tick on DIV-1.
// A synchronous clear restarts the count so bit timing can be aligned to a
// detected start edge.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  // Next count: clear wins, otherwise wrap at DIV-1.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// 8N1 UART receiver, 16x oversampling with a 3-sample majority vote per bit
// and framing-error detection. Defining UART_RX_PARITY_EN adds a parity bit
// between data and stop, the PARITY state and the parity_err output.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int DIV = 651
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_output,
  output logic       rxDone,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       frame_err
);

  uart_state_e state_q, state_d;

  logic       rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0] vld_q;
  logic       tick, start_edge, at_mid, at_end, maj;
  logic [3:0] s_q, s_d;
  logic [2:0] bit_q, bit_d;
  logic       v7_q, v7_d, v8_q, v8_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rx_output_q, rx_output_d;
  logic       done_q, done_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic       par_bad_q, par_bad_d, perr_q, perr_d;
`endif

  // vld_q marks when rx_s_q carries a real line sample rather than its
  // reset value, so a line held low through reset never looks like an edge.
  assign start_edge = (state_q == ST_IDLE) && vld_q[1] && rx_prev_q && !rx_s_q;
  assign at_mid     = tick && (s_q == 4'(SAMPLE_C));
  assign at_end     = tick && (s_q == 4'(OVS - 1));
  assign maj        = maj3(v7_q, v8_q, rx_s_q);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_edge),
    .tick  (tick)
  );

  // Input synchroniser and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      vld_q     <= 2'b00;
      rx_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      vld_q     <= {vld_q[0], 1'b1};
      rx_prev_q <= vld_q[1] ? rx_s_q : 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_edge) state_d = ST_START;
      ST_START: begin
        if (at_mid && maj)  state_d = ST_IDLE;   // glitch, not a start bit
        else if (at_end)    state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_end && (bit_q == 3'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
      ST_PARITY: if (at_end) state_d = ST_STOP;
      // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
      ST_STOP:   if (at_mid) state_d = maj ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rx_s_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: sample index, vote samples, bit index, shift reg.
  always_comb begin
    s_d   = s_q;
    v7_d  = v7_q;
    v8_d  = v8_q;
    bit_d = bit_q;
    sh_d  = sh_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    if (start_edge) begin
      s_d = 4'd0;
    end else if (tick && (state_q != ST_IDLE) && (state_q != ST_BREAK)) begin
      s_d = s_q + 4'd1;
    end
    if (tick && (s_q == 4'(SAMPLE_A))) v7_d = rx_s_q;
    if (tick && (s_q == 4'(SAMPLE_B))) v8_d = rx_s_q;
    if (state_q == ST_START) bit_d = 3'd0;
    if ((state_q == ST_DATA) && at_end) bit_d = bit_q + 3'd1;
    if ((state_q == ST_DATA) && at_mid) sh_d = {maj, sh_q[7:1]};
`ifdef UART_RX_PARITY_EN
    if ((state_q == ST_PARITY) && at_mid) par_bad_d = ((^sh_q) ^ maj) != PARITY_ODD;
`endif
  end

  // FSM outputs: one-cycle pulses and the delivered byte, registered.
  always_comb begin
    rx_output_d = rx_output_q;
    done_d      = 1'b0;
    ferr_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d      = 1'b0;
`endif
    if ((state_q == ST_STOP) && at_mid) begin
      if (maj) begin
        rx_output_d = sh_q;
        done_d      = 1'b1;
`ifdef UART_RX_PARITY_EN
        perr_d      = par_bad_q;
`endif
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= 4'd0;
      v7_q        <= 1'b1;
      v8_q        <= 1'b1;
      bit_q       <= 3'd0;
      sh_q        <= 8'h00;
      rx_output_q <= 8'h00;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      s_q         <= s_d;
      v7_q        <= v7_d;
      v8_q        <= v8_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      rx_output_q <= rx_output_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign rx_output = rx_output_q;
  assign rxDone    = done_q;
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs with DIV = 4 (64 clk per bit). Honors
// UART_RX_PARITY_EN (even parity) when defined.
module tb_uart_rx_ovs;

  localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Line falls at a negedge; 2 sync FFs + edge register put the tick counter
  // clear 2 posedges later; the mid-stop tick is tick number 16*(NBITS-1)+10,
  // and rxDone is visible the cycle after it.
  localparam int LAT = 2 + 4 * (16 * (NBITS - 1) + 10) + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_output;
  logic       rxDone;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_ovs #(
    .DIV(4)
`ifdef UART_RX_PARITY_EN
    , .PARITY_ODD(1'b0)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_output (rx_output),
    .rxDone    (rxDone),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, overlap = 0, perr_alone = 0;
  int last_done_cyc = 0, last_ferr_cyc = 0, start_cyc = 0;
  int got_q[$];

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rxDone) begin
        done_cnt++;
        got_q.push_back(int'(rx_output));
        last_done_cyc = cyc;
      end
      if (frame_err) begin
        ferr_cnt++;
        last_ferr_cyc = cyc;
      end
      if (rxDone && frame_err) overlap++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) perr_cnt++;
      if (parity_err && !rxDone) perr_alone++;
`endif
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drives one frame starting at the current negedge. rst_bit >= 0 pulses
  // rst_n low for 2 clk in the middle of that frame bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int hold,
                            input int rst_bit, input logic par_flip);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop, (^d) ^ par_flip, d, 1'b0};
`else
    bits = {1'b1, stop, d, 1'b0};
    if (par_flip) bits[10] = 1'b1;
`endif
    start_cyc = cyc;
    $display("tx frame data=0x%02h stop=%0b hold=%0d rst_bit=%0d t=%0t", d, stop, hold, rst_bit, $time);
    for (int b = 0; b < NBITS; b++) begin
      rx = bits[b];
      for (int c = 0; c < BIT_CLK; c++) begin
        if (b == rst_bit && c == 30) rst_n = 1'b0;
        if (b == rst_bit && c == 32) rst_n = 1'b1;
        @(negedge clk);
      end
    end
    repeat (hold) @(negedge clk);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    logic       exp_done;
    logic       exp_ferr;
    logic [7:0] exp_out;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int d0, f0, p0;
    tbl[0] = '{8'hA5, 1'b1, 0,   1'b1, 1'b0, 8'hA5};
    tbl[1] = '{8'h81, 1'b0, 200, 1'b0, 1'b1, 8'hA5};
    tbl[2] = '{8'h42, 1'b1, 0,   1'b1, 1'b0, 8'h42};
    tbl[3] = '{8'hF0, 1'b1, 0,   1'b1, 1'b0, 8'hF0};
    tbl[4] = '{8'h01, 1'b1, 0,   1'b1, 1'b0, 8'h01};

    // Reset with the line idle.
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_output", int'(rx_output), 0);
    check("reset_rxDone", int'(rxDone), 0);
    check("reset_frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    check("idle_no_done", done_cnt, 0);
    check("idle_no_ferr", ferr_cnt, 0);

    // Table of single frames, including a framing error held low.
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
      @(negedge clk);
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].hold, -1, 1'b0);
      repeat (100) @(negedge clk);
      check($sformatf("vec%0d_done", i), done_cnt - d0, int'(tbl[i].exp_done));
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, int'(tbl[i].exp_ferr));
      check($sformatf("vec%0d_out", i), int'(rx_output), int'(tbl[i].exp_out));
      check($sformatf("vec%0d_perr", i), perr_cnt - p0, 0);
      if (tbl[i].exp_done)
        check($sformatf("vec%0d_lat", i), last_done_cyc - start_cyc, LAT);
      else
        check($sformatf("vec%0d_ferr_lat", i), last_ferr_cyc - start_cyc, LAT);
    end

    // Back-to-back frames with no idle gap.
    got_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    send_frame(8'h00, 1'b1, 0, -1, 1'b0);
    send_frame(8'hFF, 1'b1, 0, -1, 1'b0);
    send_frame(8'h3C, 1'b1, 0, -1, 1'b0);
    repeat (100) @(negedge clk);
    check("b2b_count", done_cnt - d0, 3);
    check("b2b_byte0", (got_q.size() > 0) ? got_q[0] : -1, 8'h00);
    check("b2b_byte1", (got_q.size() > 1) ? got_q[1] : -1, 8'hFF);
    check("b2b_byte2", (got_q.size() > 2) ? got_q[2] : -1, 8'h3C);

    // Short low glitch is rejected; next frame still lands on time.
    d0 = done_cnt; f0 = ferr_cnt;
    @(negedge clk);
    $display("tx glitch 20 clk t=%0t", $time);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    send_frame(8'h5A, 1'b1, 0, -1, 1'b0);
    repeat (100) @(negedge clk);
    check("glitch_next_out", int'(rx_output), 8'h5A);
    check("glitch_next_lat", last_done_cyc - start_cyc, LAT);

    // Reset in the middle of data bit 4 discards the frame.
    d0 = done_cnt; f0 = ferr_cnt;
    @(negedge clk);
    send_frame(8'hC3, 1'b1, 0, 5, 1'b0);
    repeat (100) @(negedge clk);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_no_ferr", ferr_cnt - f0, 0);
    check("rst_mid_out", int'(rx_output), 0);
    send_frame(8'h99, 1'b1, 0, -1, 1'b0);
    repeat (100) @(negedge clk);
    check("rst_next_done", done_cnt - d0, 1);
    check("rst_next_out", int'(rx_output), 8'h99);

`ifdef UART_RX_PARITY_EN
    // Wrong even-parity bit: byte delivered with parity_err alongside rxDone.
    d0 = done_cnt; p0 = perr_cnt;
    @(negedge clk);
    send_frame(8'h07, 1'b1, 0, -1, 1'b1);
    repeat (100) @(negedge clk);
    check("par_done", done_cnt - d0, 1);
    check("par_perr", perr_cnt - p0, 1);
    check("par_out", int'(rx_output), 8'h07);
    check("par_alone", perr_alone, 0);
`endif

    check("done_ferr_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
